// File: rtl/psm_host_sequencer_if.sv
// Host-side bundle for the pseudo-softmax sequencer: logit load, start/status,
// result readback and the byte-wide link to the softmax core.
interface psm_host_sequencer_if #(
  parameter int unsigned N_ELEM = 8
);
  localparam int unsigned IW = $clog2(N_ELEM);
  localparam int unsigned SW = 8 + IW;

  logic          wr_en;
  logic [IW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          start;
  logic [IW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          busy;
  logic          done;
  logic          err_timeout;
  logic [SW-1:0] sum_out;
  logic [7:0]    dut_ui_in;
  logic [7:0]    dut_uio_in;
  logic [7:0]    dut_uo_out;
  logic [7:0]    dut_uio_out;

  modport slave (
    input  wr_en, wr_addr, wr_data, start, rd_addr, dut_uo_out, dut_uio_out,
    output rd_data, busy, done, err_timeout, sum_out, dut_ui_in, dut_uio_in
  );

  modport master (
    output wr_en, wr_addr, wr_data, start, rd_addr, dut_uo_out, dut_uio_out,
    input  rd_data, busy, done, err_timeout, sum_out, dut_ui_in, dut_uio_in
  );
endinterface

// File: rtl/psm_host_sequencer.sv
// Streams a buffered logit vector into a pseudo-softmax core, collects its
// result bytes with an idle timeout, and accumulates their sum.
module psm_host_sequencer #(
  parameter int unsigned N_ELEM  = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  psm_host_sequencer_if.slave    bus
);
  localparam int unsigned IW = $clog2(N_ELEM);
  localparam int unsigned SW = 8 + IW;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_ELEM - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RECV = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    tcnt_q, tcnt_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [7:0]    ui_q, ui_d;
  logic [7:0]    uio_q, uio_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic [7:0]    logit_q  [N_ELEM];
  logic [7:0]    logit_d  [N_ELEM];
  logic [7:0]    result_q [N_ELEM];
  logic [7:0]    result_d [N_ELEM];
  logic          out_valid;

  assign out_valid = bus.dut_uio_out[2];

  // Next-state, buffer updates and registered output values.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tcnt_d    = tcnt_q;
    sum_d     = sum_q;
    ui_d      = 8'h00;
    uio_d     = 8'h00;
    done_d    = 1'b0;
    err_d     = 1'b0;
    logit_d   = logit_q;
    result_d  = result_q;
    rd_data_d = result_q[bus.rd_addr];

    case (state_q)
      S_IDLE: begin
        if (bus.wr_en) logit_d[bus.wr_addr] = bus.wr_data;
        if (bus.start) begin
          state_d = S_SEND;
          idx_d   = '0;
          tcnt_d  = 8'h00;
          sum_d   = '0;
          ui_d    = logit_d[0];
          uio_d   = 8'h01;
        end
      end
      S_SEND: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_WAIT;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
          ui_d  = logit_q[idx_d];
          uio_d = {6'b0, (idx_d == LAST_IDX), 1'b1};
        end
      end
      S_WAIT, S_RECV: begin
        if (out_valid) begin
          result_d[idx_q] = bus.dut_uo_out;
          sum_d  = sum_q + SW'(bus.dut_uo_out);
          idx_d  = idx_q + IW'(1);
          tcnt_d = 8'h00;
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_RECV;
          end
        end else begin
          // Counter holds consecutive idle cycles since WAIT entry or last capture.
          tcnt_d = tcnt_q + 8'd1;
          if (tcnt_d == 8'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      tcnt_q    <= 8'h00;
      sum_q     <= '0;
      ui_q      <= 8'h00;
      uio_q     <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tcnt_q    <= tcnt_d;
      sum_q     <= sum_d;
      ui_q      <= ui_d;
      uio_q     <= uio_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Buffers survive reset; they simply do not update while it is asserted.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      logit_q  <= logit_d;
      result_q <= result_d;
    end
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err_timeout = err_q;
  assign bus.sum_out     = sum_q;
  assign bus.dut_ui_in   = ui_q;
  assign bus.dut_uio_in  = uio_q;
endmodule

// File: tb/tb_psm_host_sequencer.sv
// Randomized self-checking bench for psm_host_sequencer with a transaction-level
// model of the send/receive/timeout behaviour.
module tb_psm_host_sequencer;
  localparam int unsigned N_ELEM  = 8;
  localparam int unsigned TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  psm_host_sequencer_if #(.N_ELEM(N_ELEM)) bus();

  psm_host_sequencer #(.N_ELEM(N_ELEM), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int logit_m [N_ELEM];
  int res_m   [N_ELEM];
  int sum_m   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load();
    for (int i = 0; i < N_ELEM; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 3'(i);
      bus.wr_data = 8'(logit_m[i]);
      tick();
    end
    bus.wr_en = 1'b0;
  endtask

  // lat: idle cycles before first byte; gap: low cycles between bytes (<0 random);
  // fix: byte value (<0 random); n_resp: bytes offered; poke: illegal start/wr_en
  // while busy; rst_k: send index at which reset is pulsed (<0 none).
  task automatic run_vec(input int lat, input int gap, input int fix, input int n_resp,
                         input bit poke, input int rst_k);
    int j, idle, off, cyc, next_offer, d;
    bit ov, fin;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < N_ELEM; k++) begin
      chk("send_ui", 32'(bus.dut_ui_in), 32'(logit_m[k]));
      chk("send_uio", 32'(bus.dut_uio_in), (k == N_ELEM - 1) ? 32'd3 : 32'd1);
      chk("send_busy", 32'(bus.busy), 32'd1);
      if (k == rst_k) begin
        rst_n       = 1'b0;
        bus.start   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd1;
        bus.wr_data = ~8'(logit_m[1]);
        tick();
        rst_n     = 1'b1;
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_uio", 32'(bus.dut_uio_in), 32'd0);
        chk("rst_ui", 32'(bus.dut_ui_in), 32'd0);
        chk("rst_sum", 32'(bus.sum_out), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        tick();
        chk("rst_idle_busy", 32'(bus.busy), 32'd0);
        return;
      end
      if (poke && k == 2) bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
    end
    chk("wait_uio", 32'(bus.dut_uio_in), 32'd0);
    chk("wait_ui", 32'(bus.dut_ui_in), 32'd0);

    j = 0; idle = 0; off = 0; cyc = 0; next_offer = lat; sum_m = 0; fin = 1'b0;
    while (!fin) begin
      ov = (off < n_resp) && (cyc >= next_offer);
      d  = (fix < 0) ? int'($urandom_range(0, 255)) : fix;
      bus.dut_uio_out = {5'b0, ov, 2'b0};
      bus.dut_uo_out  = 8'(d);
      if (poke && cyc == 0) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd0;
        bus.wr_data = ~8'(logit_m[0]);
      end
      tick();
      cyc++;
      bus.wr_en = 1'b0;
      if (ov) begin
        off++;
        next_offer = cyc + ((gap < 0) ? int'($urandom_range(0, 5)) : gap);
        res_m[j] = d;
        sum_m += d;
        j++;
        idle = 0;
      end else begin
        idle++;
      end
      if (j == N_ELEM) begin
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("done_no_err", 32'(bus.err_timeout), 32'd0);
        chk("done_busy", 32'(bus.busy), 32'd0);
        fin = 1'b1;
      end else if (idle == TIMEOUT) begin
        chk("timeout_pulse", 32'(bus.err_timeout), 32'd1);
        chk("timeout_no_done", 32'(bus.done), 32'd0);
        chk("timeout_busy", 32'(bus.busy), 32'd0);
        fin = 1'b1;
      end else if (cyc > 2000) begin
        chk("cycle_bound", 32'(cyc), 32'd0);
        fin = 1'b1;
      end else begin
        chk("run_done", 32'(bus.done), 32'd0);
        chk("run_err", 32'(bus.err_timeout), 32'd0);
        chk("run_busy", 32'(bus.busy), 32'd1);
      end
    end

    while (off < n_resp) begin
      bus.dut_uio_out = 8'h04;
      bus.dut_uo_out  = 8'($urandom_range(0, 255));
      tick();
      off++;
      chk("post_done", 32'(bus.done), 32'd0);
      chk("post_busy", 32'(bus.busy), 32'd0);
    end
    bus.dut_uio_out = 8'h00;
    tick();
    chk("idle_done", 32'(bus.done), 32'd0);
    chk("idle_err", 32'(bus.err_timeout), 32'd0);
    chk("sum_out", 32'(bus.sum_out), 32'(sum_m));
    for (int i = 0; i < N_ELEM; i++) begin
      bus.rd_addr = 3'(i);
      tick();
      chk("rd_data", 32'(bus.rd_data), 32'(res_m[i]));
    end
  endtask

  task automatic rand_logits();
    for (int i = 0; i < N_ELEM; i++) logit_m[i] = int'($urandom_range(0, 255));
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.wr_en       = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_data     = 8'h00;
    bus.start       = 1'b0;
    bus.rd_addr     = '0;
    bus.dut_uo_out  = 8'h00;
    bus.dut_uio_out = 8'h00;
    tick();
    tick();
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_err", 32'(bus.err_timeout), 32'd0);
    chk("reset_sum", 32'(bus.sum_out), 32'd0);
    chk("reset_rd_data", 32'(bus.rd_data), 32'd0);
    chk("reset_ui", 32'(bus.dut_ui_in), 32'd0);
    chk("reset_uio", 32'(bus.dut_uio_in), 32'd0);
    rst_n = 1'b1;
    tick();

    // Logits 1..8, eight bytes of 32 after three cycles: sum 256.
    for (int i = 0; i < N_ELEM; i++) logit_m[i] = i + 1;
    load();
    run_vec(3, 0, 32, N_ELEM, 1'b0, -1);
    chk("directed_sum", 32'(bus.sum_out), 32'd256);

    // Core never answers: timeout.
    run_vec(0, 0, 0, 0, 1'b0, -1);

    // 0xFF bytes with 4-cycle gaps.
    run_vec(2, 4, 255, N_ELEM, 1'b0, -1);
    chk("gap_sum", 32'(bus.sum_out), 32'd2040);

    // Start during SEND and write during WAIT are ignored; logits checked next run.
    rand_logits();
    load();
    run_vec(1, 1, -1, N_ELEM, 1'b1, -1);
    run_vec(0, 0, -1, N_ELEM, 1'b0, -1);

    // Reset in mid-SEND, then a full rerun from retained logits.
    run_vec(0, 0, 0, N_ELEM, 1'b0, 3);
    run_vec(2, -1, -1, N_ELEM, 1'b0, -1);

    // out_valid held for ten cycles: extra bytes ignored.
    run_vec(0, 0, -1, 10, 1'b0, -1);

    // Partial response then timeout keeps partial results.
    run_vec(1, -1, -1, 3, 1'b0, -1);

    for (int r = 0; r < 10; r++) begin
      rand_logits();
      load();
      run_vec(int'($urandom_range(0, 20)), -1, -1, N_ELEM + int'($urandom_range(0, 2)),
              1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
